// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/EXEC/WB control sequencer for the 4-bit CPU datapath.
// Owns the program counter, instruction register and latched jump target.
module cpu_seq_ctrl #(
  parameter int                PC_W    = 3,
  parameter int                OP_W    = 4,
  parameter logic [OP_W-1:0]   HALT_OP = 4'hF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [OP_W-1:0] rom_data,
  input  logic [PC_W-1:0] jmp_tgt,
  input  logic            zero_flag,
  input  logic            carry_flag,
  output logic [PC_W-1:0] rom_addr,
  output logic [2:0]      alu_op,
  output logic            mux_sel,
  output logic            reg_we,
  output logic            flag_we,
  output logic            halted,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LDI = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(4);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(9);

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [OP_W-1:0] ir;
  logic [PC_W-1:0] tgt;
  logic            dec_rwe, dec_fwe, dec_mux;
  logic [2:0]      dec_alu;
  logic            take_jump;

  // Returns {reg_we, flag_we, alu_op[2:0], mux_sel}; reserved and halt opcodes decode as NOP.
  function automatic logic [5:0] decode(input logic [OP_W-1:0] op);
    logic [5:0] d;
    d = {1'b0, 1'b0, ALU_PASS, 1'b0};
    case (op)
      OP_LDI:  d = {1'b1, 1'b1, ALU_PASS, 1'b1};
      OP_ADD:  d = {1'b1, 1'b1, ALU_ADD,  1'b1};
      OP_SUB:  d = {1'b1, 1'b1, ALU_SUB,  1'b1};
      OP_AND:  d = {1'b1, 1'b1, ALU_AND,  1'b1};
      OP_OR:   d = {1'b1, 1'b1, ALU_OR,   1'b1};
      OP_XOR:  d = {1'b1, 1'b1, ALU_XOR,  1'b1};
      default: d = {1'b0, 1'b0, ALU_PASS, 1'b0};
    endcase
    return d;
  endfunction

  always_comb begin
    {dec_rwe, dec_fwe, dec_alu, dec_mux} = decode(ir);
    take_jump = (ir == OP_JMP) ||
                ((ir == OP_JZ) && zero_flag) ||
                ((ir == OP_JC) && carry_flag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= OP_NOP;
      tgt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) ir <= rom_data;
      if (state == S_EXEC)  tgt <= jmp_tgt;
      if (state == S_WB)    pc <= take_jump ? tgt : pc + PC_W'(1);
    end
  end

  // Next state: run is only looked at on instruction boundaries (IDLE, WB).
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = run ? S_FETCH : S_IDLE;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (ir == HALT_OP) ? S_HALT : S_WB;
      S_WB:    state_nxt = run ? S_FETCH : S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath controls are decoded from IR and gated by state, so strobes exist only in WB.
  always_comb begin
    alu_op  = ALU_PASS;
    mux_sel = 1'b0;
    reg_we  = 1'b0;
    flag_we = 1'b0;
    if (state == S_EXEC || state == S_WB) begin
      alu_op  = dec_alu;
      mux_sel = dec_mux;
    end
    if (state == S_WB) begin
      reg_we  = dec_rwe;
      flag_we = dec_fwe;
    end
  end

  assign halted   = (state == S_HALT);
  assign rom_addr = pc;
  assign state_o  = state;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: per-opcode vector table plus multi-cycle corner sequences.
module tb_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] rom_data;
  logic [2:0] jmp_tgt = 3'd0;
  logic       zero_flag = 1'b0;
  logic       carry_flag = 1'b0;
  logic [2:0] rom_addr;
  logic [2:0] alu_op;
  logic       mux_sel;
  logic       reg_we;
  logic       flag_we;
  logic       halted;
  logic [2:0] state_o;

  logic [3:0] rom [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  cpu_seq_ctrl #(.PC_W(3), .OP_W(4), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_data(rom_data),
    .jmp_tgt(jmp_tgt), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .rom_addr(rom_addr), .alu_op(alu_op), .mux_sel(mux_sel),
    .reg_we(reg_we), .flag_we(flag_we), .halted(halted), .state_o(state_o)
  );

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       c;
    logic [2:0] tgt;
    logic       rwe;
    logic       fwe;
    logic [2:0] alu;
    logic       mux;
    logic [2:0] pc_nxt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) rom[k] = 4'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    do_reset();
    rom[0]     = v.op;
    zero_flag  = v.z;
    carry_flag = v.c;
    jmp_tgt    = v.tgt;
    run        = 1'b1;
    step();
    check($sformatf("v%0d_fetch_state", idx), state_o, 1);
    step();
    check($sformatf("v%0d_exec_state", idx), state_o, 2);
    check($sformatf("v%0d_exec_alu", idx), alu_op, v.alu);
    check($sformatf("v%0d_exec_mux", idx), mux_sel, v.mux);
    check($sformatf("v%0d_exec_reg_we", idx), reg_we, 0);
    step();
    check($sformatf("v%0d_wb_state", idx), state_o, 3);
    check($sformatf("v%0d_wb_reg_we", idx), reg_we, v.rwe);
    check($sformatf("v%0d_wb_flag_we", idx), flag_we, v.fwe);
    check($sformatf("v%0d_wb_alu", idx), alu_op, v.alu);
    check($sformatf("v%0d_wb_mux", idx), mux_sel, v.mux);
    step();
    check($sformatf("v%0d_next_pc", idx), rom_addr, v.pc_nxt);
    check($sformatf("v%0d_next_state", idx), state_o, 1);
    check($sformatf("v%0d_next_reg_we", idx), reg_we, 0);
    run = 1'b0;
  endtask

  initial begin
    logic seen_we;
    //          op    z     c     tgt   rwe   fwe   alu   mux   pc
    vecs[0]  = '{4'h0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 3'd1};
    vecs[1]  = '{4'h1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 3'd1};
    vecs[2]  = '{4'h2, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 3'd1, 1'b1, 3'd1};
    vecs[3]  = '{4'h3, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 3'd2, 1'b1, 3'd1};
    vecs[4]  = '{4'h4, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 3'd3, 1'b1, 3'd1};
    vecs[5]  = '{4'h5, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 3'd4, 1'b1, 3'd1};
    vecs[6]  = '{4'h6, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 3'd1};
    vecs[7]  = '{4'h7, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 3'd5};
    vecs[8]  = '{4'h8, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 3'd5};
    vecs[9]  = '{4'h8, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 3'd1};
    vecs[10] = '{4'h9, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 3'd0, 1'b0, 3'd6};
    vecs[11] = '{4'h9, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 3'd0, 1'b0, 3'd1};
    vecs[12] = '{4'hA, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 3'd1};
    vecs[13] = '{4'hE, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 3'd1};
    for (int k = 0; k < 8; k++) rom[k] = 4'h0;

    // Reset values while rst_n is held low
    #12;
    check("rst_state", state_o, 0);
    check("rst_pc", rom_addr, 0);
    check("rst_alu", alu_op, 0);
    check("rst_mux", mux_sel, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_flag_we", flag_we, 0);
    check("rst_halted", halted, 0);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // All-NOP program: PC walks 0..7 and wraps, 3 clocks per instruction
    do_reset();
    run = 1'b1;
    seen_we = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("nop_walk_pc%0d", i), rom_addr, i % 8);
      check($sformatf("nop_walk_state%0d", i), state_o, 1);
      for (int c = 0; c < 3; c++) begin
        if (reg_we || flag_we) seen_we = 1'b1;
        step();
      end
    end
    check("nop_walk_no_strobe", seen_we, 0);

    // HALT at address 3 is sticky against run
    do_reset();
    rom[3] = 4'hF;
    run = 1'b1;
    step();
    for (int c = 0; c < 9; c++) step();
    check("halt_fetch_pc", rom_addr, 3);
    step();
    check("halt_exec_state", state_o, 2);
    check("halt_exec_halted", halted, 0);
    step();
    check("halt_state", state_o, 4);
    check("halt_halted", halted, 1);
    check("halt_pc", rom_addr, 3);
    for (int c = 0; c < 6; c++) begin
      run = c[0];
      step();
    end
    check("halt_sticky_state", state_o, 4);
    check("halt_sticky_pc", rom_addr, 3);
    check("halt_sticky_reg_we", reg_we, 0);
    check("halt_sticky_alu", alu_op, 0);
    rst_n = 1'b0;
    #1;
    check("halt_rst_halted", halted, 0);
    check("halt_rst_pc", rom_addr, 0);
    check("halt_rst_state", state_o, 0);

    // run dropped during EXEC of ADD: instruction still completes
    do_reset();
    rom[0] = 4'h2;
    run = 1'b1;
    step();
    step();
    check("drop_exec_state", state_o, 2);
    run = 1'b0;
    step();
    check("drop_wb_reg_we", reg_we, 1);
    check("drop_wb_flag_we", flag_we, 1);
    step();
    check("drop_idle_state", state_o, 0);
    check("drop_idle_pc", rom_addr, 1);
    check("drop_idle_reg_we", reg_we, 0);
    step();
    check("drop_idle_stays", state_o, 0);

    // Reset asserted during EXEC of LDI: no strobe afterwards, PC back to 0
    do_reset();
    rom[0] = 4'h1;
    rom[1] = 4'h1;
    run = 1'b1;
    step();
    step();
    step();
    step();
    check("abort_pc_before", rom_addr, 1);
    step();
    check("abort_exec_state", state_o, 2);
    rst_n = 1'b0;
    seen_we = 1'b0;
    #1;
    check("abort_state", state_o, 0);
    check("abort_pc", rom_addr, 0);
    for (int c = 0; c < 3; c++) begin
      if (reg_we || flag_we) seen_we = 1'b1;
      step();
    end
    check("abort_no_strobe", seen_we, 0);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
